// File: rtl/audio_i2s_pkg.sv
// Shared types and default geometry for the I2S master.
// 12.288 MHz / (2 * 32 * 4) = 48 kHz frame rate.
package audio_i2s_pkg;

   typedef enum logic {
      WAIT_LOCK,
      RUN
   } i2s_state_t;

   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_SLOT_WIDTH = 32;
   localparam int DEF_MCLK_DIV   = 4;
   localparam int DEF_LOCK_WAIT  = 1024;

endpackage

// File: rtl/audio_i2s_clkgen.sv
// Lock qualification, BCLK/LRCK generation and bit-slot timing.
// Strobes describe the cycle that follows the next clock edge.
module audio_i2s_clkgen
   import audio_i2s_pkg::*;
#(
   parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
   parameter int MCLK_DIV   = DEF_MCLK_DIV,
   parameter int LOCK_WAIT  = DEF_LOCK_WAIT
) (
   input  logic clk,
   input  logic rst,
   input  logic pll_locked,
   output logic active,
   output logic aud_bclk,
   output logic aud_lrck,
   output logic run,
   output logic enter,
   output logic fall,
   output logic rise,
   output logic frame_start,
   output logic lr,
   output logic [$clog2(SLOT_WIDTH)-1:0] slot_idx
);

   localparam int DCW = $clog2(MCLK_DIV);
   localparam int BW  = $clog2(2 * SLOT_WIDTH);
   localparam int CW  = $clog2(LOCK_WAIT + 1);
   localparam int IW  = $clog2(SLOT_WIDTH);

   localparam logic [DCW-1:0] D_LAST = DCW'(MCLK_DIV - 1);
   localparam logic [DCW-1:0] D_HALF = DCW'(MCLK_DIV / 2);
   localparam logic [BW-1:0]  B_LAST = BW'(2 * SLOT_WIDTH - 1);
   localparam logic [BW-1:0]  B_SLOT = BW'(SLOT_WIDTH);
   localparam logic [CW-1:0]  C_LAST = CW'(LOCK_WAIT - 1);

   i2s_state_t state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [DCW-1:0] d, d_nxt;
   logic [BW-1:0]  b, b_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      d_nxt     = '0;
      b_nxt     = '0;
      unique case (state)
         WAIT_LOCK: begin
            if (pll_locked) begin
               if (cnt == C_LAST) state_nxt = RUN;
               else               cnt_nxt   = cnt + 1'b1;
            end
         end
         RUN: begin
            if (!pll_locked) begin
               state_nxt = WAIT_LOCK;
            end else begin
               d_nxt = (d == D_LAST) ? '0 : d + 1'b1;
               b_nxt = b;
               if (d_nxt == '0)
                  b_nxt = (b == B_LAST) ? '0 : b + 1'b1;
            end
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   // Entering RUN lands on d=0, b=0, so it is itself a frame start.
   assign run         = (state_nxt == RUN);
   assign enter       = run && (state == WAIT_LOCK);
   assign fall        = run && (d_nxt == '0);
   assign rise        = run && (d_nxt == D_HALF);
   assign frame_start = fall && (b_nxt == '0);
   assign lr          = run && (b_nxt >= B_SLOT);
   assign slot_idx    = IW'(lr ? b_nxt - B_SLOT : b_nxt);
   assign active      = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WAIT_LOCK;
         cnt      <= '0;
         d        <= '0;
         b        <= '0;
         aud_bclk <= 1'b0;
         aud_lrck <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         d        <= d_nxt;
         b        <= b_nxt;
         aud_bclk <= run && (d_nxt >= D_HALF);
         aud_lrck <= lr;
      end
   end

endmodule

// File: rtl/audio_i2s_master.sv
// I2S master: holding register, TX/RX serialisers and strobes.
// Data is launched on BCLK fall and captured on BCLK rise.
module audio_i2s_master
   import audio_i2s_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
   parameter int MCLK_DIV   = DEF_MCLK_DIV,
   parameter int LOCK_WAIT  = DEF_LOCK_WAIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_locked,
   input  logic [DATA_WIDTH-1:0] tx_left,
   input  logic [DATA_WIDTH-1:0] tx_right,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_left,
   output logic [DATA_WIDTH-1:0] rx_right,
   output logic                  rx_valid,
   output logic                  aud_bclk,
   output logic                  aud_lrck,
   output logic                  aud_dacdat,
   input  logic                  aud_adcdat,
   output logic                  active,
   output logic                  underrun
);

   localparam int IW = $clog2(SLOT_WIDTH);
   localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH);

   logic run, enter, fall, rise, frame_start, lr;
   logic [IW-1:0] slot_idx;
   logic in_data, accept, hold_full;
   logic [DATA_WIDTH-1:0] hold_l, hold_r;
   logic [DATA_WIDTH-1:0] tx_sh_l, tx_sh_r;
   logic [DATA_WIDTH-1:0] rx_sh_l, rx_sh_r;

   audio_i2s_clkgen #(
      .SLOT_WIDTH (SLOT_WIDTH),
      .MCLK_DIV   (MCLK_DIV),
      .LOCK_WAIT  (LOCK_WAIT)
   ) u_clkgen (
      .clk         (clk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .active      (active),
      .aud_bclk    (aud_bclk),
      .aud_lrck    (aud_lrck),
      .run         (run),
      .enter       (enter),
      .fall        (fall),
      .rise        (rise),
      .frame_start (frame_start),
      .lr          (lr),
      .slot_idx    (slot_idx)
   );

   assign in_data  = (slot_idx != '0) && (slot_idx <= I_LAST);
   assign tx_ready = active && !hold_full;
   assign accept   = tx_valid && tx_ready;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         hold_full  <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
         tx_sh_l    <= '0;
         tx_sh_r    <= '0;
         rx_sh_l    <= '0;
         rx_sh_r    <= '0;
         rx_left    <= '0;
         rx_right   <= '0;
         rx_valid   <= 1'b0;
         underrun   <= 1'b0;
         aud_dacdat <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         if (accept) begin
            hold_l    <= tx_left;
            hold_r    <= tx_right;
            hold_full <= 1'b1;
         end
         // A same-edge accept never sees hold_full set, so it survives.
         if (frame_start) begin
            tx_sh_l <= hold_full ? hold_l : '0;
            tx_sh_r <= hold_full ? hold_r : '0;
            if (hold_full) hold_full <= 1'b0;
            else if (!enter) underrun <= 1'b1;
            if (!enter) begin
               rx_left  <= rx_sh_l;
               rx_right <= rx_sh_r;
               rx_valid <= 1'b1;
            end
         end
         if (fall) begin
            aud_dacdat <= 1'b0;
            if (in_data && lr)
               {aud_dacdat, tx_sh_r} <= {tx_sh_r, 1'b0};
            else if (in_data)
               {aud_dacdat, tx_sh_l} <= {tx_sh_l, 1'b0};
         end
         if (rise && in_data) begin
            if (lr) rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], aud_adcdat};
            else    rx_sh_l <= {rx_sh_l[DATA_WIDTH-2:0], aud_adcdat};
         end
      end
   end

endmodule

// File: tb/tb_audio_i2s_master.sv
// Loopback bench for audio_i2s_master with a frame-level model.
// DACDAT is wired back to ADCDAT; random pairs feed the transmitter.
module tb_audio_i2s_master;

   localparam int DW = 24;
   localparam int SW = 32;
   localparam int MD = 4;
   localparam int LW = 16;
   localparam int FR = 2 * SW * MD;

   logic clk = 1'b0;
   logic rst, pll_locked, tx_valid, tx_ready, rx_valid;
   logic aud_bclk, aud_lrck, aud_dacdat, aud_adcdat;
   logic active, underrun;
   logic [DW-1:0] tx_left, tx_right, rx_left, rx_right;

   always #5 clk = ~clk;
   assign aud_adcdat = aud_dacdat;

   audio_i2s_master #(
      .DATA_WIDTH (DW),
      .SLOT_WIDTH (SW),
      .MCLK_DIV   (MD),
      .LOCK_WAIT  (LW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .tx_left    (tx_left),
      .tx_right   (tx_right),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_left    (rx_left),
      .rx_right   (rx_right),
      .rx_valid   (rx_valid),
      .aud_bclk   (aud_bclk),
      .aud_lrck   (aud_lrck),
      .aud_dacdat (aud_dacdat),
      .aud_adcdat (aud_adcdat),
      .active     (active),
      .underrun   (underrun)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int und_cnt = 0;
   bit feed = 0;
   bit bitorder_req = 0;
   bit bitorder_seen = 0;

   int streak = 0;
   bit m_act  = 0;
   int m_p    = 0;
   bit m_hfull = 0;
   bit m_rxv  = 0;
   bit m_und  = 0;
   logic [DW-1:0] m_hl = '0, m_hr = '0;
   logic [DW-1:0] m_cl = '0, m_cr = '0;
   logic [DW-1:0] m_rxl = '0, m_rxr = '0;

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h",
                  name, cyc, got, want);
      end
   endtask

   // Frame-level model: position in run from the lock streak,
   // frame contents from the holding register at each frame start.
   initial begin : model
      bit acc;
      int ns, np;
      forever begin
         @(posedge clk);
         cyc++;
         acc = m_act && !m_hfull && tx_valid;
         ns = (rst || !pll_locked) ? 0 : streak + 1;
         streak = ns;
         m_rxv = 0;
         m_und = 0;
         if (ns < LW) begin
            m_act = 0;
            m_p = 0;
            m_hfull = 0;
            m_hl = '0; m_hr = '0;
            m_cl = '0; m_cr = '0;
            m_rxl = '0; m_rxr = '0;
         end else begin
            np = ns - LW;
            if (np % FR == 0) begin
               if (np != 0) begin
                  m_und = !m_hfull;
                  m_rxv = 1;
                  m_rxl = m_cl;
                  m_rxr = m_cr;
               end
               m_cl = m_hfull ? m_hl : '0;
               m_cr = m_hfull ? m_hr : '0;
               m_hfull = 0;
            end
            if (acc) begin
               m_hl = tx_left;
               m_hr = tx_right;
               m_hfull = 1;
            end
            m_p = np;
            m_act = 1;
         end
      end
   end

   function automatic logic [54:0] model_vec();
      int d, b, i;
      logic [DW-1:0] s;
      logic dac;
      d = m_p % MD;
      b = (m_p / MD) % (2 * SW);
      i = b % SW;
      s = (b >= SW) ? m_cr : m_cl;
      dac = 1'b0;
      if (m_act && i >= 1 && i <= DW) dac = s[DW-i];
      return {m_act, m_act && !m_hfull,
              m_act && (d >= MD / 2), m_act && (b >= SW),
              dac, m_rxv, m_und, m_rxl, m_rxr};
   endfunction

   initial begin : compare
      logic [63:0] fb;
      bit fr_und, prev_lrck;
      int last_rise;
      fb = '0;
      fr_und = 0;
      prev_lrck = 0;
      last_rise = -1;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            check("outputs",
                  64'({active, tx_ready, aud_bclk, aud_lrck,
                       aud_dacdat, rx_valid, underrun,
                       rx_left, rx_right}),
                  64'(model_vec()));
            if (underrun === 1'b1) und_cnt++;
            if (!active) last_rise = -1;
            if (aud_lrck && !prev_lrck) begin
               if (last_rise >= 0)
                  check("lrck_period", 64'(cyc - last_rise), 64'(FR));
               last_rise = cyc;
            end
            prev_lrck = aud_lrck;
            if (m_act) begin
               if (m_p % MD == 0) fb[(m_p / MD) % (2 * SW)] = aud_dacdat;
               if (m_p % FR == 0) fr_und = m_und;
               if (m_p % FR == FR - 1) begin
                  if (m_cl == 24'h800001 && m_cr == 24'h7FFFFE) begin
                     check("bitorder", fb, 64'h00FF_FFFC_0100_0002);
                     bitorder_seen = 1;
                  end
                  if (fr_und) check("underrun_frame_zero", fb, 64'h0);
                  if (m_p == FR - 1) check("first_frame_zero", fb, 64'h0);
               end
            end
         end
      end
   end

   initial begin : feeder
      bit seen;
      tx_valid = 0;
      tx_left  = '0;
      tx_right = '0;
      forever begin
         @(posedge clk);
         seen = tx_valid && tx_ready;
         #2;
         if (!feed) begin
            tx_valid = 0;
         end else if (!tx_valid || seen) begin
            if (bitorder_req) begin
               tx_left  = 24'h800001;
               tx_right = 24'h7FFFFE;
               bitorder_req = 0;
            end else begin
               tx_left  = DW'($urandom);
               tx_right = DW'($urandom);
            end
            tx_valid = 1;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_p(input int ph);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(m_act && m_p % FR == ph) && n < 2000);
      if (n >= 2000) begin
         total++;
         bad++;
         $display("FAIL wait_phase got=%0d want=%0d", n, ph);
      end
   endtask

   task automatic wait_active(input int r);
      int n;
      n = 0;
      while (active !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("relock_delay", 64'(cyc - r), 64'(LW));
   endtask

   initial begin : driver
      int r;
      rst = 1;
      pll_locked = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      repeat (3) @(posedge clk);
      #1 pll_locked = 1;
      while (cyc != 20) @(negedge clk);
      check("lock_early", 64'(active), 64'h0);
      @(negedge clk);
      check("lock_rise", 64'(active), 64'h1);
      feed = 1;

      wait_p(10);
      bitorder_req = 1;
      repeat (3 * FR) @(posedge clk);

      wait_p(5);
      r = und_cnt;
      feed = 0;
      repeat (2 * FR) @(posedge clk);
      #1 feed = 1;
      check("underrun_once", 64'(und_cnt - r), 64'h1);
      repeat (2 * FR) @(posedge clk);

      wait_p(160);
      pll_locked = 0;
      @(negedge clk);
      @(negedge clk);
      check("drop_zero",
            64'({active, aud_bclk, aud_lrck, aud_dacdat, tx_ready}),
            64'h0);
      @(posedge clk);
      #1 pll_locked = 1;
      repeat (10) @(posedge clk);
      #1 pll_locked = 0;
      @(posedge clk);
      #1 pll_locked = 1;
      r = cyc;
      wait_active(r);
      repeat (2 * FR) @(posedge clk);

      wait_p(160);
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      check("rst_zero",
            64'({active, aud_bclk, aud_lrck, aud_dacdat, tx_ready}),
            64'h0);
      @(posedge clk);
      #1 rst = 0;
      r = cyc;
      wait_active(r);
      repeat (3 * FR) @(posedge clk);

      check("bitorder_seen", 64'(bitorder_seen), 64'h1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
